imem_responder: RTL and testbench

- Instruction-memory responder for the fetch-side io request/response handshake (io_reqValid/io_addr in, io_respValid/io_rdata out).
- Word-addressed on-chip array, DEPTH words, mapped at BASE_ADDR.
- Answers each accepted request after a programmable latency, including a zero-latency same-cycle path.
- A side load port fills the array for simulation and boot.

---
 rtl/imem_responder.sv | 175 +++++++++++++++++
 tb/tb_imem_responder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-memory responder for a fetch-side pulse request / pulse
//   response handshake. A word-addressed array of DEPTH 32-bit words is
//   mapped at BASE_ADDR. Each request accepted in IDLE is answered LATENCY
//   cycles later (LATENCY=0 answers in the same cycle). A side load port
//   fills the array at any time.
//
//   Optional build macro: IMEM_LFSR_DELAY_EN adds 0..3 pseudo-random
//   cycles (8-bit Fibonacci LFSR) to the latency of every request.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   io_reqValid/io_addr  one-cycle request pulse and byte address
//   io_respValid/io_rdata one-cycle response pulse and read word (0 otherwise)
//   load_wen/load_addr/load_wdata  array write port (word address [31:2])
//   busy                 a request is outstanding
//   err_overlap          sticky: request seen while busy
//   err_range            sticky: accepted request was outside the array
module imem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_reqValid,
  input  logic [31:0] io_addr,
  output logic        io_respValid,
  output logic [31:0] io_rdata,
  input  logic        load_wen,
  input  logic [29:0] load_addr,
  input  logic [31:0] load_wdata,
  output logic        busy,
  output logic        err_overlap,
  output logic        err_range
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [4:0]  LAT_W     = 5'(LATENCY);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_err_overlap;
  logic        r_err_range;
  logic [31:0] r_mem [DEPTH];

  logic [29:0]   w_req_off;
  logic [29:0]   w_pend_off;
  logic [29:0]   w_load_off;
  logic          w_req_in_range;
  logic          w_pend_in_range;
  logic          w_load_in_range;
  logic [AW-1:0] w_req_idx;
  logic [AW-1:0] w_pend_idx;
  logic [AW-1:0] w_load_idx;
  logic          w_accept;
  logic [4:0]    w_eff_lat;
  logic          w_zero_resp;
  logic          w_wait_resp;
  logic          w_unused;

  // Word offsets from the base; the subtraction wraps, so anything below
  // the base lands far above DEPTH and one unsigned compare covers both ends.
  assign w_req_off       = io_addr[31:2] - BASE_WORD;
  assign w_pend_off      = r_addr[31:2] - BASE_WORD;
  assign w_load_off      = load_addr - BASE_WORD;
  assign w_req_in_range  = (w_req_off < DEPTH_W);
  assign w_pend_in_range = (w_pend_off < DEPTH_W);
  assign w_load_in_range = (w_load_off < DEPTH_W);
  assign w_req_idx       = w_req_off[AW-1:0];
  assign w_pend_idx      = w_pend_off[AW-1:0];
  assign w_load_idx      = w_load_off[AW-1:0];

  // Byte-lane bits never select anything.
  assign w_unused = ^{io_addr[1:0], r_addr[1:0]};

  assign w_accept    = io_reqValid && (r_state == S_IDLE);
  assign w_zero_resp = w_accept && (w_eff_lat == 5'd0);
  assign w_wait_resp = (r_state == S_WAIT) && (r_cnt == 5'd0);

`ifdef IMEM_LFSR_DELAY_EN
  logic [7:0] r_lfsr;

  // Latency uses the LFSR value from before this request advances it.
  assign w_eff_lat = LAT_W + {3'b000, r_lfsr[1:0]};

  // LFSR, taps 8,6,5,4, stepped once per accepted request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end else begin
      r_lfsr <= r_lfsr;
    end
  end
`else
  assign w_eff_lat = LAT_W;
`endif

  // Request FSM, latency counter, latched address and sticky error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 5'd0;
      r_addr        <= 32'h0000_0000;
      r_err_overlap <= 1'b0;
      r_err_range   <= 1'b0;
    end else begin
      if (io_reqValid && (r_state == S_WAIT)) begin
        r_err_overlap <= 1'b1;
      end
      if (w_accept && !w_req_in_range) begin
        r_err_range <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= io_addr;
            // A zero effective latency was answered this cycle; stay idle.
            if (w_eff_lat != 5'd0) begin
              r_state <= S_WAIT;
              r_cnt   <= w_eff_lat - 5'd1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 5'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 5'd0;
        end
      endcase
    end
  end

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (load_wen && w_load_in_range) begin
      r_mem[w_load_idx] <= load_wdata;
    end
  end

  // Response is read combinationally, so a write landing on the response
  // edge is not yet visible while an earlier write already is.
  always_comb begin
    io_respValid = 1'b0;
    io_rdata     = 32'h0000_0000;
    if (w_wait_resp) begin
      io_respValid = 1'b1;
      io_rdata     = w_pend_in_range ? r_mem[w_pend_idx] : 32'h0000_0000;
    end else if (w_zero_resp) begin
      io_respValid = 1'b1;
      io_rdata     = w_req_in_range ? r_mem[w_req_idx] : 32'h0000_0000;
    end else begin
      io_respValid = 1'b0;
      io_rdata     = 32'h0000_0000;
    end
  end

  assign busy        = (r_state == S_WAIT);
  assign err_overlap = r_err_overlap;
  assign err_range   = r_err_range;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: four instances (LATENCY 0,2,3,4, DEPTH 16)
// share clock, reset, address and load port; each has its own request line.
module tb_imem_responder;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [29:0] BASE_W = 30'h2000_0000;
  localparam int          DEP    = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] addr;
  logic        load_wen;
  logic [29:0] load_addr;
  logic [31:0] load_wdata;
  logic [3:0]  rv, bsy, eov, erg;
  logic [31:0] rd [4];

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEP];

  always #5 clock = ~clock;

  imem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(0)) u_l0 (
    .clock(clock), .reset(reset), .io_reqValid(req[0]), .io_addr(addr),
    .io_respValid(rv[0]), .io_rdata(rd[0]), .load_wen(load_wen),
    .load_addr(load_addr), .load_wdata(load_wdata), .busy(bsy[0]),
    .err_overlap(eov[0]), .err_range(erg[0]));
  imem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .io_reqValid(req[1]), .io_addr(addr),
    .io_respValid(rv[1]), .io_rdata(rd[1]), .load_wen(load_wen),
    .load_addr(load_addr), .load_wdata(load_wdata), .busy(bsy[1]),
    .err_overlap(eov[1]), .err_range(erg[1]));
  imem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(3)) u_l3 (
    .clock(clock), .reset(reset), .io_reqValid(req[2]), .io_addr(addr),
    .io_respValid(rv[2]), .io_rdata(rd[2]), .load_wen(load_wen),
    .load_addr(load_addr), .load_wdata(load_wdata), .busy(bsy[2]),
    .err_overlap(eov[2]), .err_range(erg[2]));
  imem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(4)) u_l4 (
    .clock(clock), .reset(reset), .io_reqValid(req[3]), .io_addr(addr),
    .io_respValid(rv[3]), .io_rdata(rd[3]), .load_wen(load_wen),
    .load_addr(load_addr), .load_wdata(load_wdata), .busy(bsy[3]),
    .err_overlap(eov[3]), .err_range(erg[3]));

  function automatic int lat_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    longint unsigned ua;
    ua = longint'(a);
    return (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEP);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    longint unsigned ua;
    ua = longint'(a);
    if (in_range(a)) return model_mem[int'((ua - longint'(BASE)) / 4)];
    else return 32'h0000_0000;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0000; load_wen = 1'b0; addr = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_word(input int idx, input logic [31:0] d);
    load_wen = 1'b1; load_addr = BASE_W + 30'(idx); load_wdata = d;
    tick();
    load_wen = 1'b0;
    model_mem[idx] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b0000; load_wen = 1'b0; addr = 32'h0;
    load_addr = 30'h0; load_wdata = 32'h0;
    at_neg();
    for (int k = 0; k < 4; k++) begin
      checks++; if (rv[k] !== 1'b0) begin errors++; $display("FAIL reset_resp k=%0d got %b exp 0", k, rv[k]); end
      checks++; if (rd[k] !== 32'h0) begin errors++; $display("FAIL reset_rdata k=%0d got %h exp 0", k, rd[k]); end
      checks++; if (bsy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy k=%0d got %b exp 0", k, bsy[k]); end
      checks++; if (eov[k] !== 1'b0) begin errors++; $display("FAIL reset_ovl k=%0d got %b exp 0", k, eov[k]); end
      checks++; if (erg[k] !== 1'b0) begin errors++; $display("FAIL reset_rng k=%0d got %b exp 0", k, erg[k]); end
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_latency2();
    do_reset();
    load_word(3, 32'h0000_0013);
    req[1] = 1'b1; addr = 32'h8000_000C;
    for (int c = 0; c < 4; c++) begin
      at_neg();
      checks++; if (rv[1] !== (c == 2)) begin errors++; $display("FAIL lat2_resp c=%0d got %b exp %b", c, rv[1], c == 2); end
      checks++; if (rd[1] !== ((c == 2) ? 32'h0000_0013 : 32'h0)) begin errors++; $display("FAIL lat2_rdata c=%0d got %h", c, rd[1]); end
      checks++; if (bsy[1] !== (c == 1 || c == 2)) begin errors++; $display("FAIL lat2_busy c=%0d got %b", c, bsy[1]); end
      tick();
      req[1] = 1'b0;
    end
  endtask

  task automatic test_zero_latency();
    do_reset();
    load_word(0, 32'h00A0_0093);
    req[0] = 1'b1; addr = 32'h8000_0002;
    at_neg();
    checks++; if (rv[0] !== 1'b1) begin errors++; $display("FAIL lat0_resp got %b exp 1", rv[0]); end
    checks++; if (rd[0] !== 32'h00A0_0093) begin errors++; $display("FAIL lat0_rdata got %h exp 00a00093", rd[0]); end
    checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL lat0_busy got %b exp 0", bsy[0]); end
    tick();
    req[0] = 1'b0;
    at_neg();
    checks++; if (rv[0] !== 1'b0) begin errors++; $display("FAIL lat0_idle_resp got %b exp 0", rv[0]); end
    checks++; if (rd[0] !== 32'h0) begin errors++; $display("FAIL lat0_idle_rdata got %h exp 0", rd[0]); end
    checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL lat0_idle_busy got %b exp 0", bsy[0]); end
    tick();
  endtask

  task automatic test_out_of_range();
    do_reset();
    req[1] = 1'b1; addr = 32'h7FFF_FFFC;
    for (int c = 0; c < 6; c++) begin
      at_neg();
      checks++; if (rv[1] !== (c == 2)) begin errors++; $display("FAIL oor_resp c=%0d got %b", c, rv[1]); end
      checks++; if (rd[1] !== 32'h0) begin errors++; $display("FAIL oor_rdata c=%0d got %h exp 0", c, rd[1]); end
      checks++; if (erg[1] !== (c >= 1)) begin errors++; $display("FAIL oor_err c=%0d got %b exp %b", c, erg[1], c >= 1); end
      tick();
      req[1] = 1'b0;
    end
    // Upper boundary on the same-cycle instance: last word in, next word out.
    load_word(15, 32'h5A5A_0F0F);
    req[0] = 1'b1; addr = 32'h8000_003F;
    at_neg();
    checks++; if (rd[0] !== 32'h5A5A_0F0F) begin errors++; $display("FAIL top_word_rdata got %h exp 5a5a0f0f", rd[0]); end
    tick();
    addr = 32'h8000_0040;
    at_neg();
    checks++; if (erg[0] !== 1'b0) begin errors++; $display("FAIL top_word_err got %b exp 0", erg[0]); end
    checks++; if (rv[0] !== 1'b1) begin errors++; $display("FAIL past_top_resp got %b exp 1", rv[0]); end
    checks++; if (rd[0] !== 32'h0) begin errors++; $display("FAIL past_top_rdata got %h exp 0", rd[0]); end
    tick();
    req[0] = 1'b0;
    at_neg();
    checks++; if (erg[0] !== 1'b1) begin errors++; $display("FAIL past_top_err got %b exp 1", erg[0]); end
    checks++; if (erg[2] !== 1'b0) begin errors++; $display("FAIL idle_inst_err got %b exp 0", erg[2]); end
    tick();
  endtask

  task automatic test_overlap();
    do_reset();
    load_word(2, 32'h1234_5678);
    load_word(6, 32'h9ABC_DEF0);
    for (int c = 0; c < 9; c++) begin
      req[2] = (c == 0 || c == 1 || c == 4);
      addr = (c == 4) ? 32'h8000_0018 : 32'h8000_0008;
      at_neg();
      checks++; if (rv[2] !== (c == 3 || c == 7)) begin errors++; $display("FAIL ovl_resp c=%0d got %b", c, rv[2]); end
      checks++; if (rd[2] !== ((c == 3) ? 32'h1234_5678 : (c == 7) ? 32'h9ABC_DEF0 : 32'h0)) begin errors++; $display("FAIL ovl_rdata c=%0d got %h", c, rd[2]); end
      checks++; if (bsy[2] !== ((c >= 1 && c <= 3) || (c >= 5 && c <= 7))) begin errors++; $display("FAIL ovl_busy c=%0d got %b", c, bsy[2]); end
      checks++; if (eov[2] !== (c >= 2)) begin errors++; $display("FAIL ovl_flag c=%0d got %b exp %b", c, eov[2], c >= 2); end
      tick();
    end
    req[2] = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    load_word(7, 32'hDEAD_BEEF);
    req[3] = 1'b1; addr = 32'h8000_001C;
    tick();
    req[3] = 1'b0;
    at_neg();
    checks++; if (bsy[3] !== 1'b1) begin errors++; $display("FAIL rmw_busy_before got %b exp 1", bsy[3]); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (bsy[3] !== 1'b0) begin errors++; $display("FAIL rmw_busy_async got %b exp 0", bsy[3]); end
    for (int c = 2; c <= 10; c++) begin
      at_neg();
      checks++; if (rv[3] !== 1'b0) begin errors++; $display("FAIL rmw_resp c=%0d got %b exp 0", c, rv[3]); end
      checks++; if (bsy[3] !== 1'b0) begin errors++; $display("FAIL rmw_busy c=%0d got %b exp 0", c, bsy[3]); end
      tick();
      if (c == 2) reset = 1'b0;
    end
    req[3] = 1'b1; addr = 32'h8000_001C;
    for (int c = 0; c < 5; c++) begin
      at_neg();
      checks++; if (rv[3] !== (c == 4)) begin errors++; $display("FAIL retain_resp c=%0d got %b", c, rv[3]); end
      checks++; if (rd[3] !== ((c == 4) ? 32'hDEAD_BEEF : 32'h0)) begin errors++; $display("FAIL retain_rdata c=%0d got %h", c, rd[3]); end
      tick();
      req[3] = 1'b0;
    end
  endtask

  task automatic test_load_race();
    do_reset();
    load_word(5, 32'h1111_2222);
    req[1] = 1'b1; addr = 32'h8000_0014;
    tick();
    req[1] = 1'b0;
    load_wen = 1'b1; load_addr = BASE_W + 30'd5; load_wdata = 32'hCAFE_F00D;
    tick();
    load_wen = 1'b0; model_mem[5] = 32'hCAFE_F00D;
    at_neg();
    checks++; if (rv[1] !== 1'b1) begin errors++; $display("FAIL race_early_resp got %b exp 1", rv[1]); end
    checks++; if (rd[1] !== 32'hCAFE_F00D) begin errors++; $display("FAIL race_early_rdata got %h exp cafef00d", rd[1]); end
    tick();
    load_word(5, 32'h1111_2222);
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    tick();
    load_wen = 1'b1; load_addr = BASE_W + 30'd5; load_wdata = 32'hCAFE_F00D;
    at_neg();
    checks++; if (rv[1] !== 1'b1) begin errors++; $display("FAIL race_late_resp got %b exp 1", rv[1]); end
    checks++; if (rd[1] !== 32'h1111_2222) begin errors++; $display("FAIL race_late_rdata got %h exp 11112222", rd[1]); end
    tick();
    load_wen = 1'b0; model_mem[5] = 32'hCAFE_F00D;
    req[0] = 1'b1;
    at_neg();
    checks++; if (rd[0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL race_after_rdata got %h exp cafef00d", rd[0]); end
    tick();
    req[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) load_word(8 + i, $urandom());
    for (int c = 0; c < 10; c++) begin
      req[1] = (c % 3 == 0) && (c < 9);
      addr = BASE + 32'(4 * (8 + c / 3));
      at_neg();
      checks++; if (rv[1] !== ((c % 3 == 2) && (c <= 8))) begin errors++; $display("FAIL b2b_resp c=%0d got %b", c, rv[1]); end
      checks++; if (rd[1] !== (((c % 3 == 2) && (c <= 8)) ? model_mem[8 + c / 3] : 32'h0)) begin errors++; $display("FAIL b2b_rdata c=%0d got %h", c, rd[1]); end
      checks++; if (bsy[1] !== ((c % 3 != 0) && (c <= 8))) begin errors++; $display("FAIL b2b_busy c=%0d got %b", c, bsy[1]); end
      checks++; if (eov[1] !== 1'b0) begin errors++; $display("FAIL b2b_ovl c=%0d got %b exp 0", c, eov[1]); end
      tick();
    end
    req[1] = 1'b0;
  endtask

  task automatic test_random();
    bit          pend_v [4];
    int          pend_cyc [4];
    logic [31:0] pend_addr [4];
    bit          m_ov [4];
    bit          m_rg [4];
    bit          was, exp_v;
    logic [31:0] exp_d;
    longint      lw;
    do_reset();
    for (int i = 0; i < DEP; i++) load_word(i, $urandom());
    for (int k = 0; k < 4; k++) begin
      pend_v[k] = 1'b0; pend_cyc[k] = 0; pend_addr[k] = 32'h0; m_ov[k] = 1'b0; m_rg[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 4; k++)
        req[k] = pend_v[k] ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       addr = 32'h7FFF_FFFC + 32'($urandom_range(0, 3));
        1:       addr = 32'h8000_0040 + 32'($urandom_range(0, 3));
        2:       addr = $urandom();
        default: addr = BASE + 32'($urandom_range(0, 63));
      endcase
      load_wen   = ($urandom_range(0, 2) == 0);
      load_addr  = BASE_W + 30'($urandom_range(0, 19)) - 30'd2;
      load_wdata = $urandom();
      at_neg();
      for (int k = 0; k < 4; k++) begin
        exp_v = (lat_of(k) == 0 && req[k]) || (pend_v[k] && pend_cyc[k] == cyc);
        exp_d = !exp_v ? 32'h0 : (lat_of(k) == 0) ? ref_read(addr) : ref_read(pend_addr[k]);
        checks++; if (rv[k] !== exp_v) begin errors++; $display("FAIL rnd_resp k=%0d cyc=%0d got %b exp %b", k, cyc, rv[k], exp_v); end
        checks++; if (rd[k] !== exp_d) begin errors++; $display("FAIL rnd_rdata k=%0d cyc=%0d got %h exp %h", k, cyc, rd[k], exp_d); end
        checks++; if (bsy[k] !== pend_v[k]) begin errors++; $display("FAIL rnd_busy k=%0d cyc=%0d got %b exp %b", k, cyc, bsy[k], pend_v[k]); end
        checks++; if (eov[k] !== m_ov[k]) begin errors++; $display("FAIL rnd_ovl k=%0d cyc=%0d got %b exp %b", k, cyc, eov[k], m_ov[k]); end
        checks++; if (erg[k] !== m_rg[k]) begin errors++; $display("FAIL rnd_rng k=%0d cyc=%0d got %b exp %b", k, cyc, erg[k], m_rg[k]); end
        // Advance the model across the coming clock edge.
        was = pend_v[k];
        if (was && req[k]) m_ov[k] = 1'b1;
        if (was && pend_cyc[k] == cyc) pend_v[k] = 1'b0;
        if (!was && req[k]) begin
          if (!in_range(addr)) m_rg[k] = 1'b1;
          if (lat_of(k) > 0) begin
            pend_v[k] = 1'b1; pend_cyc[k] = cyc + lat_of(k); pend_addr[k] = addr;
          end
        end
      end
      lw = longint'(load_addr) - longint'(BASE_W);
      if (load_wen && lw >= 0 && lw < DEP) model_mem[int'(lw)] = load_wdata;
      tick();
    end
    req = 4'b0000; load_wen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency2();
    test_zero_latency();
    test_out_of_range();
    test_overlap();
    test_reset_mid_wait();
    test_load_race();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
